// File: rtl/axis_source_pkg.sv
// Shared types and constants for the AXI-stream pattern source and its
// future read-side checker.
package axis_source_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } src_state_t;

    typedef enum logic [1:0] {
        PAT_INCR  = 2'd0,
        PAT_LFSR  = 2'd1,
        PAT_CONST = 2'd2
    } pattern_t;

    // Maximal-length 32-bit polynomial, Galois right-shift form.
    localparam int unsigned LFSR_WIDTH = 32;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 32'h8020_0003;

    // The reserved encoding falls back to the incrementing pattern.
    function automatic pattern_t decode_mode(input logic [1:0] mode);
        pattern_t pat;
        case (mode)
            2'd1:    pat = PAT_LFSR;
            2'd2:    pat = PAT_CONST;
            default: pat = PAT_INCR;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One step of a Galois LFSR (right shift, feedback from bit 0).
// Purely combinational so it can be shared by generator and checker.
module lfsr_step
    import axis_source_pkg::*;
#(
    parameter int unsigned         DWIDTH = 32,
    parameter logic [DWIDTH-1:0]   TAPS   = DWIDTH'(LFSR_TAPS)
) (
    input  logic [DWIDTH-1:0] state_i,
    output logic [DWIDTH-1:0] next_o
);

    always_comb begin
        next_o = state_i >> 1;
        if (state_i[0]) begin
            next_o = next_o ^ TAPS;
        end
    end

endmodule

// File: rtl/axis_pattern_source.sv
// Packetised AXI-stream traffic generator: configurable length, count,
// inter-packet gap and payload pattern, fully registered outputs.
module axis_pattern_source
    import axis_source_pkg::*;
#(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned TKEEPWIDTH = DWIDTH / 8,
    parameter int unsigned LENWIDTH   = 16,
    parameter int unsigned TUSERWIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [DWIDTH-1:0]     seed,
    input  logic [LENWIDTH-1:0]   pkt_len,
    input  logic [LENWIDTH-1:0]   num_pkts,
    input  logic [LENWIDTH-1:0]   gap_cycles,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DWIDTH-1:0]     m_tdata,
    output logic [TKEEPWIDTH-1:0] m_tkeep,
    output logic [TKEEPWIDTH-1:0] m_tstrb,
    output logic                  m_tlast,
    output logic [TUSERWIDTH-1:0] m_tuser,
    output logic [7:0]            m_tid,
    output logic [7:0]            m_tdest,
    output logic                  busy,
    output logic                  done,
    output logic [LENWIDTH-1:0]   pkts_sent
);

    localparam logic [LENWIDTH-1:0] LEN_ONE = LENWIDTH'(1);

    src_state_t              state_q, state_d;
    pattern_t                pat_q, pat_d;
    logic [LENWIDTH-1:0]     len_q, len_d;
    logic [LENWIDTH-1:0]     num_q, num_d;
    logic [LENWIDTH-1:0]     gap_len_q, gap_len_d;
    logic [LENWIDTH-1:0]     beat_q, beat_d;
    logic [LENWIDTH-1:0]     gap_cnt_q, gap_cnt_d;
    logic [LENWIDTH-1:0]     pkts_sent_q, pkts_sent_d;
    logic                    abort_pend_q, abort_pend_d;
    logic                    tvalid_q, tvalid_d;
    logic [DWIDTH-1:0]       tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic [TUSERWIDTH-1:0]   tuser_q, tuser_d;
    logic [TKEEPWIDTH-1:0]   tkeep_q, tkeep_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    pattern_t                mode_dec;
    logic                    xfer;
    logic [LENWIDTH-1:0]     pkts_inc;
    logic [LENWIDTH-1:0]     beat_inc;
    logic [DWIDTH-1:0]       lfsr_next;
    logic [DWIDTH-1:0]       next_payload;

    lfsr_step #(
        .DWIDTH (DWIDTH),
        .TAPS   (DWIDTH'(LFSR_TAPS))
    ) u_lfsr (
        .state_i (tdata_q),
        .next_o  (lfsr_next)
    );

    assign mode_dec = decode_mode(mode);
    assign xfer     = tvalid_q && m_tready;
    assign pkts_inc = pkts_sent_q + LEN_ONE;
    assign beat_inc = beat_q + LEN_ONE;

    // Payload of the beat following the one currently presented.
    always_comb begin
        case (pat_q)
            PAT_LFSR:  next_payload = lfsr_next;
            PAT_CONST: next_payload = tdata_q;
            default:   next_payload = tdata_q + DWIDTH'(1);
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        num_d        = num_q;
        gap_len_d    = gap_len_q;
        beat_d       = beat_q;
        gap_cnt_d    = gap_cnt_q;
        pkts_sent_d  = pkts_sent_q;
        abort_pend_d = abort_pend_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d        = mode_dec;
                    len_d        = (pkt_len == '0) ? LEN_ONE : pkt_len;
                    num_d        = num_pkts;
                    gap_len_d    = gap_cycles;
                    beat_d       = '0;
                    gap_cnt_d    = '0;
                    pkts_sent_d  = '0;
                    abort_pend_d = 1'b0;
                    tdata_d      = (mode_dec == PAT_LFSR && seed == '0) ? '1 : seed;
                    tlast_d      = (pkt_len <= LEN_ONE);
                    tuser_d      = '0;
                    state_d      = (num_pkts == '0) ? DONE : SEND;
                end
            end

            SEND: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                // First cycle after start: payload is loaded, now present it.
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                end else if (xfer) begin
                    tdata_d = next_payload;
                    if (tlast_q) begin
                        pkts_sent_d = pkts_inc;
                        beat_d      = '0;
                        tlast_d     = (len_q == LEN_ONE);
                        tuser_d     = TUSERWIDTH'(pkts_inc);
                        if (pkts_inc == num_q || abort_pend_q || abort) begin
                            state_d  = DONE;
                            tvalid_d = 1'b0;
                        end else if (gap_len_q != '0) begin
                            state_d   = GAP;
                            tvalid_d  = 1'b0;
                            gap_cnt_d = gap_len_q - LEN_ONE;
                        end
                    end else begin
                        beat_d  = beat_inc;
                        tlast_d = (beat_inc == len_q - LEN_ONE);
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = DONE;
                end else if (gap_cnt_q == '0) begin
                    state_d  = SEND;
                    tvalid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_ONE;
                end
            end

            DONE: begin
                abort_pend_d = 1'b0;
                state_d      = IDLE;
            end

            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase

        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
        tkeep_d = {TKEEPWIDTH{tvalid_d}};
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            pat_q        <= PAT_INCR;
            len_q        <= '0;
            num_q        <= '0;
            gap_len_q    <= '0;
            beat_q       <= '0;
            gap_cnt_q    <= '0;
            pkts_sent_q  <= '0;
            abort_pend_q <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= '0;
            tkeep_q      <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            num_q        <= num_d;
            gap_len_q    <= gap_len_d;
            beat_q       <= beat_d;
            gap_cnt_q    <= gap_cnt_d;
            pkts_sent_q  <= pkts_sent_d;
            abort_pend_q <= abort_pend_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tkeep_q      <= tkeep_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign m_tvalid  = tvalid_q;
    assign m_tdata   = tdata_q;
    assign m_tkeep   = tkeep_q;
    assign m_tstrb   = tkeep_q;
    assign m_tlast   = tlast_q;
    assign m_tuser   = tuser_q;
    assign m_tid     = 8'h00;
    assign m_tdest   = 8'h00;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pkts_sent = pkts_sent_q;

endmodule
